vram_bus_arbiter: RTL and testbench
===================================

Name: vram_bus_arbiter

Overview:
- Shares the single 32-bit VRAM bus between the CPU register-access port and the two layer renderers (layer 0, layer 1).
- Each requester uses a strobe/ack master handshake: 18-bit word address, strobe held until ack.
- The arbiter forwards one transaction at a time to the VRAM controller and returns read data plus a one-cycle ack to the granted requester.
- Arbitration: CPU has fixed priority; the two layers alternate round-robin.

Parameters:
- none: widths are fixed (address 18, data 32).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cpu_addr  in  18  CPU word address
cpu_wrdata  in  32  CPU write data
cpu_write  in  1  1=write, 0=read; qualified by cpu_strobe
cpu_strobe  in  1  CPU request
cpu_ack  out  1  CPU transaction done (1 cycle)
l0_addr  in  18  layer 0 read address
l0_strobe  in  1  layer 0 request
l0_ack  out  1  layer 0 done (1 cycle)
l1_addr  in  18  layer 1 read address
l1_strobe  in  1  layer 1 request
l1_ack  out  1  layer 1 done (1 cycle)
bus_rddata  out  32  read data shared by all requesters; valid in the ack cycle
mem_addr  out  18  VRAM controller address
mem_wrdata  out  32  VRAM write data
mem_write  out  1  VRAM write enable
mem_strobe  out  1  VRAM request
mem_ack  in  1  VRAM transaction complete; mem_rddata valid this cycle
mem_rddata  in  32  VRAM read data

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named rst.
- Reset values:
  - All outputs 0: acks, mem_strobe, mem_write, mem_addr, mem_wrdata, bus_rddata.
  - state=IDLE; rr_ptr=layer 0.
- State machine:
  - IDLE: if any strobe is high, pick a grantee; register mem_addr, mem_write and mem_wrdata; set mem_strobe=1; go to BUSY.
  - IDLE with no strobes: stay in IDLE.
  - BUSY: hold mem_strobe and all mem_* signals stable until mem_ack=1.
  - On mem_ack in BUSY: mem_strobe<=0; bus_rddata<=mem_rddata (read or write); the grantee's ack<=1; go to DONE.
  - DONE: the ack is high for exactly this one cycle; cleared on exit; go to IDLE. No new grant is made in DONE, so the requester has one cycle to drop its strobe.
- Priority:
  - cpu_strobe wins unconditionally.
  - Otherwise the layer selected by rr_ptr wins if requesting, else the other layer.
  - After a layer grant, rr_ptr points to the other layer. A CPU grant leaves rr_ptr unchanged.
- Layer grants force mem_write=0; mem_wrdata keeps its previous value (don't-care).
- Latency:
  - Strobe sampled in IDLE at cycle N; mem_strobe high from N+1.
  - mem_ack at cycle M; ack high at M+1.
  - Minimum transaction is 3 cycles (mem_ack in the first BUSY cycle).
- bus_rddata holds its value until the next mem_ack.
- Requester rules:
  - Strobe and address stay stable until ack.
  - A strobe still high in the IDLE cycle after DONE is treated as a new request (back-to-back allowed).
  - A requester dropping its strobe while its transaction is in BUSY does not abort it: the transaction completes and the ack is still issued.
- mem_ack in IDLE or DONE is ignored.
- Strobes that change during BUSY or DONE do not affect the current grant.
- rst asserted mid-transaction: next cycle everything is at reset values; no ack issued; the memory side must tolerate the dropped mem_strobe.
- Starvation: the CPU can starve the layers indefinitely if it strobes continuously; this is acceptable by design. The layers can never starve each other.

Test Plan:
- Single CPU write: cpu_addr=18'h01234, cpu_wrdata=32'hDEADBEEF, cpu_write=1; mem_ack 2 cycles after mem_strobe.
  -> mem_addr=01234, mem_write=1, mem_wrdata=DEADBEEF held through BUSY; cpu_ack one cycle, one cycle after mem_ack.
- Layer 0 read: l0_addr=18'h00100; mem_rddata=32'hA5A5_0F0F with mem_ack.
  -> l0_ack pulse; bus_rddata=A5A50F0F in the ack cycle; mem_write=0.
- Layers 0 and 1 both strobing continuously from reset, mem_ack every first BUSY cycle.
  -> grant order L0,L1,L0,L1; one ack every 3 cycles; no grant is made in a DONE cycle.
- CPU and both layers strobing in the same cycle, rr_ptr=L1.
  -> order CPU, L1, L0; rr_ptr unchanged by the CPU grant.
- rst pulsed during BUSY with l1_strobe high.
  -> next cycle mem_strobe=0 and l1_ack=0, rr_ptr=L0; after release L1 is re-granted and completes normally.
- Spurious mem_ack in IDLE; l0_strobe dropped mid-BUSY.
  -> the spurious mem_ack is ignored (no ack, bus_rddata unchanged); the BUSY transaction still completes and issues l0_ack.

Source files
------------

// File: rtl/vram_bus_arbiter.sv
// -----------------------------------------------------------------------------
// vram_bus_arbiter
//
// Shares the single 32-bit VRAM bus between three strobe/ack masters: the CPU
// register-access port (read/write) and the two layer renderers (read only).
// Exactly one transaction is forwarded to the VRAM controller at a time.
//
// Arbitration: the CPU has fixed priority over the layers; the two layers
// alternate round-robin through rr_ptr, so neither layer can starve the other.
//
// Transaction sequence: IDLE (grant) -> BUSY (wait for mem_ack) -> DONE (ack).
// No grant is made in DONE, which gives the finished requester one cycle to
// drop its strobe before the arbiter samples the strobes again.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cpu_addr/wrdata/write/strobe CPU request (18-bit word address, 32-bit data)
//   cpu_ack                      CPU done, one-cycle pulse
//   l0_addr/strobe, l0_ack       layer 0 read request and one-cycle done pulse
//   l1_addr/strobe, l1_ack       layer 1 read request and one-cycle done pulse
//   bus_rddata                   read data for all requesters, valid with ack
//   mem_addr/wrdata/write/strobe VRAM controller request, held stable in BUSY
//   mem_ack, mem_rddata          VRAM completion and read data
// -----------------------------------------------------------------------------
module vram_bus_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] cpu_addr,
    input  logic [31:0] cpu_wrdata,
    input  logic        cpu_write,
    input  logic        cpu_strobe,
    output logic        cpu_ack,
    input  logic [17:0] l0_addr,
    input  logic        l0_strobe,
    output logic        l0_ack,
    input  logic [17:0] l1_addr,
    input  logic        l1_strobe,
    output logic        l1_ack,
    output logic [31:0] bus_rddata,
    output logic [17:0] mem_addr,
    output logic [31:0] mem_wrdata,
    output logic        mem_write,
    output logic        mem_strobe,
    input  logic        mem_ack,
    input  logic [31:0] mem_rddata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] GNT_CPU = 2'd0;
    localparam logic [1:0] GNT_L0  = 2'd1;
    localparam logic [1:0] GNT_L1  = 2'd2;

    state_t      state_q,      state_d;
    logic        rr_ptr_q,     rr_ptr_d;     // 0: layer 0 preferred, 1: layer 1 preferred
    logic [1:0]  grant_q,      grant_d;
    logic [17:0] mem_addr_q,   mem_addr_d;
    logic [31:0] mem_wrdata_q, mem_wrdata_d;
    logic        mem_write_q,  mem_write_d;
    logic        mem_strobe_q, mem_strobe_d;
    logic [31:0] bus_rddata_q, bus_rddata_d;
    logic        cpu_ack_q,    cpu_ack_d;
    logic        l0_ack_q,     l0_ack_d;
    logic        l1_ack_q,     l1_ack_d;
    logic        pick_l1_s;

    // Next-state and next-output computation for the arbitration FSM.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        mem_addr_d   = mem_addr_q;
        mem_wrdata_d = mem_wrdata_q;
        mem_write_d  = mem_write_q;
        mem_strobe_d = mem_strobe_q;
        bus_rddata_d = bus_rddata_q;
        // Acks are single-cycle pulses: only the BUSY->DONE transition raises one.
        cpu_ack_d    = 1'b0;
        l0_ack_d     = 1'b0;
        l1_ack_d     = 1'b0;
        pick_l1_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_strobe) begin
                    // CPU grant leaves the layer round-robin pointer untouched.
                    grant_d      = GNT_CPU;
                    mem_addr_d   = cpu_addr;
                    mem_wrdata_d = cpu_wrdata;
                    mem_write_d  = cpu_write;
                    mem_strobe_d = 1'b1;
                    state_d      = ST_BUSY;
                end else if (l0_strobe || l1_strobe) begin
                    // Preferred layer wins if it requests, otherwise the other one.
                    if (rr_ptr_q) begin
                        pick_l1_s = l1_strobe;
                    end else begin
                        pick_l1_s = !l0_strobe;
                    end
                    if (pick_l1_s) begin
                        grant_d    = GNT_L1;
                        mem_addr_d = l1_addr;
                        rr_ptr_d   = 1'b0;
                    end else begin
                        grant_d    = GNT_L0;
                        mem_addr_d = l0_addr;
                        rr_ptr_d   = 1'b1;
                    end
                    // Layers only read; mem_wrdata keeps its stale value.
                    mem_write_d  = 1'b0;
                    mem_strobe_d = 1'b1;
                    state_d      = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_BUSY: begin
                if (mem_ack) begin
                    // Data is captured for writes too; requesters ignore it then.
                    mem_strobe_d = 1'b0;
                    bus_rddata_d = mem_rddata;
                    case (grant_q)
                        GNT_CPU: cpu_ack_d = 1'b1;
                        GNT_L0:  l0_ack_d  = 1'b1;
                        GNT_L1:  l1_ack_d  = 1'b1;
                        default: cpu_ack_d = 1'b0;
                    endcase
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end

            ST_DONE: begin
                // Strobes are not sampled here so the finished requester can drop its strobe.
                state_d = ST_IDLE;
            end

            default: begin
                mem_strobe_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State and registered-output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= 1'b0;
            grant_q      <= GNT_CPU;
            mem_addr_q   <= 18'd0;
            mem_wrdata_q <= 32'd0;
            mem_write_q  <= 1'b0;
            mem_strobe_q <= 1'b0;
            bus_rddata_q <= 32'd0;
            cpu_ack_q    <= 1'b0;
            l0_ack_q     <= 1'b0;
            l1_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            mem_addr_q   <= mem_addr_d;
            mem_wrdata_q <= mem_wrdata_d;
            mem_write_q  <= mem_write_d;
            mem_strobe_q <= mem_strobe_d;
            bus_rddata_q <= bus_rddata_d;
            cpu_ack_q    <= cpu_ack_d;
            l0_ack_q     <= l0_ack_d;
            l1_ack_q     <= l1_ack_d;
        end
    end

    assign cpu_ack    = cpu_ack_q;
    assign l0_ack     = l0_ack_q;
    assign l1_ack     = l1_ack_q;
    assign bus_rddata = bus_rddata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wrdata = mem_wrdata_q;
    assign mem_write  = mem_write_q;
    assign mem_strobe = mem_strobe_q;

endmodule

// File: tb/tb_vram_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_bus_arbiter
//
// Directed scenarios plus a randomized run. Inputs are driven and outputs are
// sampled on the falling edge of clk; the DUT acts on the rising edge.
// The randomized run keeps a transaction-level model: a set of pending
// requests, the round-robin preference, and the rule that a grant appears one
// cycle after strobes are sampled while the arbiter is free, with the ack one
// cycle after mem_ack and a one-cycle gap before the next grant.
// -----------------------------------------------------------------------------
module tb_vram_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] cpu_addr;
    logic [31:0] cpu_wrdata;
    logic        cpu_write;
    logic        cpu_strobe;
    logic        cpu_ack;
    logic [17:0] l0_addr;
    logic        l0_strobe;
    logic        l0_ack;
    logic [17:0] l1_addr;
    logic        l1_strobe;
    logic        l1_ack;
    logic [31:0] bus_rddata;
    logic [17:0] mem_addr;
    logic [31:0] mem_wrdata;
    logic        mem_write;
    logic        mem_strobe;
    logic        mem_ack;
    logic [31:0] mem_rddata;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    vram_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata), .cpu_write(cpu_write),
        .cpu_strobe(cpu_strobe), .cpu_ack(cpu_ack),
        .l0_addr(l0_addr), .l0_strobe(l0_strobe), .l0_ack(l0_ack),
        .l1_addr(l1_addr), .l1_strobe(l1_strobe), .l1_ack(l1_ack),
        .bus_rddata(bus_rddata),
        .mem_addr(mem_addr), .mem_wrdata(mem_wrdata), .mem_write(mem_write),
        .mem_strobe(mem_strobe), .mem_ack(mem_ack), .mem_rddata(mem_rddata)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter used for ack spacing.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic clear_inputs();
        cpu_addr = '0; cpu_wrdata = '0; cpu_write = 1'b0; cpu_strobe = 1'b0;
        l0_addr = '0; l0_strobe = 1'b0; l1_addr = '0; l1_strobe = 1'b0;
        mem_ack = 1'b0; mem_rddata = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if ({cpu_ack, l0_ack, l1_ack, mem_strobe, mem_write} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000", {cpu_ack, l0_ack, l1_ack, mem_strobe, mem_write});
        end
        n_chk++;
        if ({mem_addr, mem_wrdata, bus_rddata} !== 82'd0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h wr=%h rd=%h expected all 0", mem_addr, mem_wrdata, bus_rddata);
        end
        rst = 1'b0;
    endtask

    task automatic test_cpu_write();
        apply_reset();
        cpu_addr = 18'h01234; cpu_wrdata = 32'hDEADBEEF; cpu_write = 1'b1; cpu_strobe = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_chk++;
            if ({mem_strobe, mem_write, mem_addr, mem_wrdata, cpu_ack} !== {1'b1, 1'b1, 18'h01234, 32'hDEADBEEF, 1'b0}) begin
                n_fail++;
                $display("FAIL cpu_write_busy%0d: got stb=%b wr=%b addr=%h data=%h ack=%b expected 1 1 01234 deadbeef 0",
                         i, mem_strobe, mem_write, mem_addr, mem_wrdata, cpu_ack);
            end
        end
        mem_ack = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({cpu_ack, l0_ack, l1_ack, mem_strobe} !== 4'b1000) begin
            n_fail++;
            $display("FAIL cpu_write_ack: got ack/l0/l1/stb=%b expected 1000", {cpu_ack, l0_ack, l1_ack, mem_strobe});
        end
        mem_ack = 1'b0; cpu_strobe = 1'b0;
        @(negedge clk);
        n_chk++;
        if (cpu_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL cpu_write_ack_pulse: got %b expected 0", cpu_ack);
        end
    endtask

    task automatic test_l0_read();
        l0_addr = 18'h00100; l0_strobe = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({mem_strobe, mem_write, mem_addr} !== {1'b1, 1'b0, 18'h00100}) begin
            n_fail++;
            $display("FAIL l0_read_req: got stb=%b wr=%b addr=%h expected 1 0 00100", mem_strobe, mem_write, mem_addr);
        end
        mem_ack = 1'b1; mem_rddata = 32'hA5A5_0F0F;
        @(negedge clk);
        n_chk++;
        if ({cpu_ack, l0_ack, l1_ack} !== 3'b010 || bus_rddata !== 32'hA5A5_0F0F) begin
            n_fail++;
            $display("FAIL l0_read_ack: got acks=%b rd=%h expected 010 a5a50f0f", {cpu_ack, l0_ack, l1_ack}, bus_rddata);
        end
        mem_ack = 1'b0; mem_rddata = 32'h0; l0_strobe = 1'b0;
        @(negedge clk);
        n_chk++;
        if (l0_ack !== 1'b0 || bus_rddata !== 32'hA5A5_0F0F) begin
            n_fail++;
            $display("FAIL l0_read_hold: got ack=%b rd=%h expected 0 a5a50f0f", l0_ack, bus_rddata);
        end
    endtask

    // Layer round-robin now prefers layer 1 (last grant was layer 0).
    task automatic test_cpu_priority();
        logic [17:0] exp_addr [3];
        logic [2:0]  exp_ack  [3];
        logic [31:0] rd;
        bit          seen;
        exp_addr[0] = 18'h3000A; exp_ack[0] = 3'b100;
        exp_addr[1] = 18'h00300; exp_ack[1] = 3'b001;
        exp_addr[2] = 18'h00200; exp_ack[2] = 3'b010;
        cpu_addr = 18'h3000A; cpu_write = 1'b0; l0_addr = 18'h00200; l1_addr = 18'h00300;
        cpu_strobe = 1'b1; l0_strobe = 1'b1; l1_strobe = 1'b1;
        for (int t = 0; t < 3; t++) begin
            seen = 1'b0;
            for (int w = 0; w < 5 && !seen; w++) begin
                @(negedge clk);
                seen = mem_strobe;
            end
            n_chk++;
            if (!seen || mem_addr !== exp_addr[t]) begin
                n_fail++;
                $display("FAIL prio_grant%0d: got stb=%b addr=%h expected 1 %h", t, seen, mem_addr, exp_addr[t]);
            end
            rd = $urandom; mem_ack = 1'b1; mem_rddata = rd;
            @(negedge clk);
            n_chk++;
            if ({cpu_ack, l0_ack, l1_ack} !== exp_ack[t] || bus_rddata !== rd) begin
                n_fail++;
                $display("FAIL prio_ack%0d: got acks=%b rd=%h expected %b %h", t, {cpu_ack, l0_ack, l1_ack}, bus_rddata, exp_ack[t], rd);
            end
            mem_ack = 1'b0;
            if (exp_ack[t][2]) cpu_strobe = 1'b0;
            if (exp_ack[t][1]) l0_strobe = 1'b0;
            if (exp_ack[t][0]) l1_strobe = 1'b0;
        end
    endtask

    task automatic test_layer_alternation();
        int  last_ack_cyc;
        bit  seen;
        apply_reset();
        l0_addr = 18'h00111; l1_addr = 18'h00222; l0_strobe = 1'b1; l1_strobe = 1'b1;
        last_ack_cyc = -1;
        for (int t = 0; t < 4; t++) begin
            seen = 1'b0;
            for (int w = 0; w < 5 && !seen; w++) begin
                @(negedge clk);
                seen = mem_strobe;
            end
            n_chk++;
            if (!seen || mem_addr !== ((t % 2 == 0) ? 18'h00111 : 18'h00222)) begin
                n_fail++;
                $display("FAIL alt_grant%0d: got stb=%b addr=%h expected 1 %h", t, seen, mem_addr,
                         (t % 2 == 0) ? 18'h00111 : 18'h00222);
            end
            mem_ack = 1'b1; mem_rddata = 32'h1000 + t;
            @(negedge clk);
            mem_ack = 1'b0;
            n_chk++;
            if ({l0_ack, l1_ack} !== ((t % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL alt_ack%0d: got l0/l1=%b expected %b", t, {l0_ack, l1_ack}, (t % 2 == 0) ? 2'b10 : 2'b01);
            end
            if (last_ack_cyc >= 0) begin
                n_chk++;
                if (cyc - last_ack_cyc != 3) begin
                    n_fail++;
                    $display("FAIL alt_spacing%0d: got %0d cycles expected 3", t, cyc - last_ack_cyc);
                end
            end
            last_ack_cyc = cyc;
        end
        l0_strobe = 1'b0; l1_strobe = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        bit seen;
        apply_reset();
        l1_addr = 18'h00333; l1_strobe = 1'b1;
        @(negedge clk);
        n_chk++;
        if (mem_strobe !== 1'b1 || mem_addr !== 18'h00333) begin
            n_fail++;
            $display("FAIL rst_busy_grant: got stb=%b addr=%h expected 1 00333", mem_strobe, mem_addr);
        end
        rst = 1'b1; mem_ack = 1'b1; mem_rddata = 32'h5555_AAAA;
        @(negedge clk);
        n_chk++;
        if ({mem_strobe, l1_ack, mem_addr, bus_rddata} !== 52'd0) begin
            n_fail++;
            $display("FAIL rst_busy_clear: got stb=%b ack=%b addr=%h rd=%h expected all 0", mem_strobe, l1_ack, mem_addr, bus_rddata);
        end
        rst = 1'b0; mem_ack = 1'b0;
        seen = 1'b0;
        for (int w = 0; w < 5 && !seen; w++) begin
            @(negedge clk);
            seen = mem_strobe;
        end
        n_chk++;
        if (!seen || mem_addr !== 18'h00333) begin
            n_fail++;
            $display("FAIL rst_busy_regrant: got stb=%b addr=%h expected 1 00333", seen, mem_addr);
        end
        mem_ack = 1'b1; mem_rddata = 32'h0BAD_F00D;
        @(negedge clk);
        mem_ack = 1'b0; l1_strobe = 1'b0;
        n_chk++;
        if (l1_ack !== 1'b1 || bus_rddata !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL rst_busy_complete: got ack=%b rd=%h expected 1 0badf00d", l1_ack, bus_rddata);
        end
    endtask

    task automatic test_spurious_and_drop();
        apply_reset();
        mem_ack = 1'b1; mem_rddata = 32'hBAD0_BAD0;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({cpu_ack, l0_ack, l1_ack, mem_strobe} !== 4'b0 || bus_rddata !== 32'h0) begin
            n_fail++;
            $display("FAIL spurious_ack: got acks/stb=%b rd=%h expected 0000 00000000", {cpu_ack, l0_ack, l1_ack, mem_strobe}, bus_rddata);
        end
        l0_addr = 18'h00444; l0_strobe = 1'b1;
        @(negedge clk);
        l0_strobe = 1'b0;
        @(negedge clk);
        n_chk++;
        if (mem_strobe !== 1'b1 || mem_addr !== 18'h00444) begin
            n_fail++;
            $display("FAIL drop_hold: got stb=%b addr=%h expected 1 00444", mem_strobe, mem_addr);
        end
        mem_ack = 1'b1; mem_rddata = 32'h1234_5678;
        @(negedge clk);
        mem_ack = 1'b0;
        n_chk++;
        if (l0_ack !== 1'b1 || bus_rddata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL drop_complete: got ack=%b rd=%h expected 1 12345678", l0_ack, bus_rddata);
        end
    endtask

    // Randomized traffic against a transaction-level model (0=cpu, 1=l0, 2=l1).
    task automatic test_random();
        bit          pend [3];
        bit          sp   [3];
        logic [17:0] raddr [3];
        logic        rwrite;
        logic [31:0] rwdata, last_rd, due_data;
        bit          pref_l1, outst, ack_due, elig_prev;
        int          gnt, lat, bcnt, last_ack;
        logic [2:0]  exp_ack;
        apply_reset();
        for (int i = 0; i < 3; i++) begin pend[i] = 1'b0; sp[i] = 1'b0; raddr[i] = '0; end
        rwrite = 1'b0; rwdata = '0; last_rd = '0; due_data = '0;
        pref_l1 = 1'b0; outst = 1'b0; ack_due = 1'b0; elig_prev = 1'b0;
        gnt = 0; lat = 0; bcnt = 0; last_ack = -10;
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            exp_ack = ack_due ? (3'b001 << gnt) : 3'b000;
            n_chk++;
            if ({l1_ack, l0_ack, cpu_ack} !== exp_ack) begin
                n_fail++;
                $display("FAIL rnd_ack@%0d: got l1/l0/cpu=%b expected %b", k, {l1_ack, l0_ack, cpu_ack}, exp_ack);
            end
            if (ack_due) begin
                last_rd = due_data; outst = 1'b0; pend[gnt] = 1'b0; last_ack = k; ack_due = 1'b0;
            end
            n_chk++;
            if (bus_rddata !== last_rd) begin
                n_fail++;
                $display("FAIL rnd_rddata@%0d: got %h expected %h", k, bus_rddata, last_rd);
            end
            if (!outst) begin
                n_chk++;
                if (mem_strobe !== elig_prev) begin
                    n_fail++;
                    $display("FAIL rnd_grant@%0d: got stb=%b expected %b", k, mem_strobe, elig_prev);
                end
                if (elig_prev) begin
                    if (sp[0])              gnt = 0;
                    else if (pref_l1)       gnt = sp[2] ? 2 : 1;
                    else                    gnt = sp[1] ? 1 : 2;
                    if (gnt != 0) pref_l1 = (gnt == 1);
                    outst = 1'b1; bcnt = 0; lat = $urandom_range(0, 3);
                end
            end
            if (outst) begin
                n_chk++;
                if (mem_strobe !== 1'b1 || mem_addr !== raddr[gnt] || mem_write !== ((gnt == 0) ? rwrite : 1'b0)
                    || (gnt == 0 && rwrite && mem_wrdata !== rwdata)) begin
                    n_fail++;
                    $display("FAIL rnd_busy@%0d: got stb=%b addr=%h wr=%b data=%h expected grantee %0d addr=%h",
                             k, mem_strobe, mem_addr, mem_write, mem_wrdata, gnt, raddr[gnt]);
                end
            end
            // Drive the memory side for the next edge.
            mem_ack = 1'b0; mem_rddata = $urandom;
            if (outst) begin
                if (bcnt == lat) begin
                    mem_ack = 1'b1; ack_due = 1'b1; due_data = mem_rddata;
                end
                bcnt++;
            end else if ($urandom_range(0, 5) == 0) begin
                mem_ack = 1'b1;
            end
            // New requests from idle requesters; pending ones hold strobe and address.
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    raddr[i] = 18'($urandom);
                    if (i == 0) begin rwrite = 1'($urandom); rwdata = $urandom; end
                end
                sp[i] = pend[i];
            end
            cpu_strobe = pend[0]; cpu_addr = raddr[0]; cpu_write = rwrite; cpu_wrdata = rwdata;
            l0_strobe = pend[1]; l0_addr = raddr[1];
            l1_strobe = pend[2]; l1_addr = raddr[2];
            elig_prev = !outst && (k > last_ack) && (pend[0] || pend[1] || pend[2]);
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_cpu_write();
        test_l0_read();
        test_cpu_priority();
        test_layer_alternation();
        test_reset_mid_busy();
        test_spurious_and_drop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
